// File: rtl/data_sram_responder.sv
// Data-SRAM port responder: byte-writable word RAM plus an MMIO window
// holding LED, scratch and free-running timer registers.
module data_sram_responder #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [15:0] MMIO_HI    = 16'hBFAF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  output logic        timer_irq
);

  localparam logic [15:0] OFF_LED = 16'hF000;
  localparam logic [15:0] OFF_SCR = 16'hF004;
  localparam logic [15:0] OFF_TMR = 16'hE000;
  localparam int          DEPTH   = 1 << ADDR_WIDTH;

  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] led_q;
  logic [31:0] scratch;
  logic [31:0] timer;

  logic                  mmio;
  logic [15:0]           off;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  wr;
  logic                  rd;
  logic                  ram_we;
  logic                  tmr_we;
  logic [31:0]           mmio_rd;
  logic                  unused_ok;

  assign mmio      = data_sram_addr[31:16] == MMIO_HI;
  assign off       = data_sram_addr[15:0];
  assign idx       = data_sram_addr[ADDR_WIDTH+1:2];
  assign wr        = data_sram_en && (data_sram_wen != 4'b0000);
  assign rd        = data_sram_en && (data_sram_wen == 4'b0000);
  assign tmr_we    = wr && mmio && (off == OFF_TMR);
  assign led       = led_q[15:0];
  assign unused_ok = ^data_sram_addr[1:0];

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // A write sampled while reset is held must not reach the array.
  always_comb begin
    ram_we = wr && !mmio && !rst;
  end

  always_comb begin
    mmio_rd = 32'h0;
    unique case (1'b1)
      off == OFF_LED: mmio_rd = led_q;
      off == OFF_SCR: mmio_rd = scratch;
      off == OFF_TMR: mmio_rd = timer;
      default:        mmio_rd = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++)
        if (data_sram_wen[i])
          mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_sram_rdata <= 32'h0;
    end else if (rd) begin
      data_sram_rdata <= mmio ? mmio_rd : mem[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q   <= 32'h0;
      scratch <= 32'h0;
    end else if (wr && mmio) begin
      if (off == OFF_LED)
        led_q <= merge(led_q, data_sram_wdata, data_sram_wen);
      if (off == OFF_SCR)
        scratch <= merge(scratch, data_sram_wdata, data_sram_wen);
    end
  end

  // A timer write replaces the increment for that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer     <= 32'h0;
      timer_irq <= 1'b0;
    end else if (tmr_we) begin
      timer     <= merge(timer, data_sram_wdata, data_sram_wen);
      timer_irq <= 1'b0;
    end else begin
      timer     <= timer + 32'd1;
      timer_irq <= timer == 32'hFFFF_FFFF;
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed plus randomized checks of data_sram_responder against
// a transaction-level model of the RAM, MMIO registers and timer.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [15:0] led;
  logic        irq;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_mem [0:1023];
  logic [31:0] m_led;
  logic [31:0] m_scr;
  logic [31:0] m_tmr;
  logic [31:0] m_rdata;
  logic        m_irq;

  data_sram_responder dut (
    .clk(clk),
    .rst(rst),
    .data_sram_en(en),
    .data_sram_wen(wen),
    .data_sram_addr(addr),
    .data_sram_wdata(wdata),
    .data_sram_rdata(rdata),
    .led(led),
    .timer_irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] o,
                                         input logic [31:0] n,
                                         input logic [3:0] b);
    logic [31:0] r;
    r = 0;
    for (int i = 0; i < 4; i++)
      r += (b[i] ? (n >> (8*i)) & 32'hFF : (o >> (8*i)) & 32'hFF)
           << (8*i);
    return r;
  endfunction

  task automatic model_reset();
    m_led = 0; m_scr = 0; m_tmr = 0; m_rdata = 0; m_irq = 0;
  endtask

  // Advance the model by one accepted edge using the pre-edge request.
  task automatic model_edge(input logic e, input logic [3:0] w,
                            input logic [31:0] a, input logic [31:0] d);
    logic        io;
    logic [15:0] o;
    int          k;
    logic        twr;
    io  = (a / 65536) == 32'hBFAF;
    o   = a[15:0];
    k   = (a / 4) % 1024;
    twr = e && w != 0 && io && o == 16'hE000;
    if (e && w == 0) begin
      if (!io) m_rdata = m_mem[k];
      else if (o == 16'hF000) m_rdata = m_led;
      else if (o == 16'hF004) m_rdata = m_scr;
      else if (o == 16'hE000) m_rdata = m_tmr;
      else m_rdata = 0;
    end
    if (e && w != 0) begin
      if (!io) m_mem[k] = bmerge(m_mem[k], d, w);
      else if (o == 16'hF000) m_led = bmerge(m_led, d, w);
      else if (o == 16'hF004) m_scr = bmerge(m_scr, d, w);
    end
    m_irq = !twr && m_tmr == 32'hFFFF_FFFF;
    m_tmr = twr ? bmerge(m_tmr, d, w) : m_tmr + 1;
  endtask

  task automatic cyc(input logic e, input logic [3:0] w,
                     input logic [31:0] a, input logic [31:0] d);
    en = e; wen = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    model_edge(e, w, a, d);
    chk("rdata", rdata, m_rdata);
    chk("led", {16'h0, led}, {16'h0, m_led[15:0]});
    chk("irq", {31'h0, irq}, {31'h0, m_irq});
    en = 0; wen = 0;
  endtask

  initial begin
    int          op;
    logic [31:0] a;
    rst = 1; en = 0; wen = 0; addr = 0; wdata = 0;
    model_reset();
    for (int i = 0; i < 1024; i++) m_mem[i] = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_rdata", rdata, 0);
    chk("rst_led", {16'h0, led}, 0);
    rst = 0;

    cyc(1, 4'hF, 32'h10, 32'hDEADBEEF);
    cyc(1, 4'h0, 32'h10, 0);
    chk("rw_full", rdata, 32'hDEADBEEF);
    cyc(1, 4'h0, 32'h1010, 0);
    chk("alias", rdata, 32'hDEADBEEF);
    cyc(1, 4'b0101, 32'h10, 32'h11223344);
    cyc(1, 4'h0, 32'h10, 0);
    chk("merge1", rdata, 32'hDE22BE44);
    cyc(1, 4'b1000, 32'h10, 32'hAA000000);
    cyc(1, 4'h0, 32'h10, 0);
    chk("merge2", rdata, 32'hAA22BE44);

    cyc(1, 4'hF, 32'hBFAFF000, 32'h0001A5A5);
    chk("led_wr", {16'h0, led}, 32'hA5A5);
    cyc(1, 4'h0, 32'hBFAFF000, 0);
    chk("led_rd", rdata, 32'h0001A5A5);
    cyc(1, 4'hF, 32'hBFAF1234, 32'h12345678);
    cyc(1, 4'h0, 32'hBFAF1234, 0);
    chk("unmapped", rdata, 0);
    chk("led_keep", {16'h0, led}, 32'hA5A5);

    cyc(1, 4'hF, 32'hBFAFE000, 32'hFFFFFFFE);
    chk("irq_load", {31'h0, irq}, 0);
    cyc(0, 0, 0, 0);
    chk("irq_ff", {31'h0, irq}, 0);
    cyc(0, 0, 0, 0);
    chk("irq_wrap", {31'h0, irq}, 1);
    cyc(1, 4'h0, 32'hBFAFE000, 0);
    chk("tmr_wrap_rd", rdata, 0);
    chk("irq_one", {31'h0, irq}, 0);

    cyc(1, 4'h0, 32'h10, 0);
    cyc(1, 4'hF, 32'h20, 32'h5);
    chk("hold_wr", rdata, 32'hAA22BE44);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      chk("hold_idle", rdata, 32'hAA22BE44);
    end
    cyc(1, 4'h0, 32'h20, 0);
    chk("rd_after", rdata, 32'h5);

    for (int i = 0; i < 16; i++)
      cyc(1, 4'hF, 32'(i * 4), $urandom);
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 9);
      a  = {$urandom_range(0, 15), 12'h0} |
           32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      if (op == 8) begin
        case ($urandom_range(0, 3))
          0: a = 32'hBFAFF000;
          1: a = 32'hBFAFF004;
          2: a = 32'hBFAFE000;
          default: a = 32'hBFAF0000 | $urandom_range(0, 65535);
        endcase
      end
      if (op < 4) cyc(1, 4'($urandom), a, $urandom);
      else if (op == 9) cyc(0, 4'($urandom), a, $urandom);
      else cyc(1, (op == 8 && $urandom_range(0, 1) == 1)
                  ? 4'($urandom) : 4'h0, a, $urandom);
    end

    en = 1; wen = 4'hF; addr = 32'h10; wdata = 32'hCAFEF00D;
    #4 rst = 1;
    #1;
    chk("arst_rdata", rdata, 0);
    chk("arst_led", {16'h0, led}, 0);
    chk("arst_irq", {31'h0, irq}, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 0; en = 0; wen = 0;
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    cyc(1, 4'h0, 32'hBFAFE000, 0);
    chk("tmr_idle", rdata, 32'd5);
    cyc(1, 4'h0, 32'h10, 0);
    chk("no_partial", rdata, m_mem[4]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Responder end of the core's data-SRAM port.
- Accepts the core's single-cycle en/wen/addr/wdata requests and returns read data with a fixed 1-cycle latency, with no handshake.
- Backs the port with a byte-writable word RAM plus a small MMIO window containing a LED register, a scratch register and a free-running 32-bit timer.
- Sits outside the core in the SoC top, directly on the data_sram_* wires.

Parameters:
- ADDR_WIDTH, 10, word-address bits of the RAM (depth 2^ADDR_WIDTH words; default 4 KB).
- MMIO_HI, 16'hBFAF, value of addr[31:16] that selects the MMIO window.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- data_sram_en  input  1  request valid this cycle
- data_sram_wen  input  4  byte write enables; 4'b0000 with en=1 means a read
- data_sram_addr  input  32  byte address; bits [1:0] ignored
- data_sram_wdata  input  32  write data, byte lane i = bits [8i+7:8i]
- data_sram_rdata  output  32  read data, registered
- led  output  16  LED register, low half
- timer_irq  output  1  registered pulse when the timer wraps

Behaviour:
- Reset (async, rst=1):
  - data_sram_rdata=0, led=0, scratch=0, timer=0, timer_irq=0.
  - RAM contents are not reset.
  - rst asserted mid-access aborts the access; no partial write lands.
- Request acceptance:
  - A request is sampled on every rising edge where en=1; no stall or backpressure exists.
  - en=0: no state change except the timer; rdata holds.
- Decode:
  - mmio = (addr[31:16]==MMIO_HI). Otherwise RAM at index addr[ADDR_WIDTH+1:2].
  - Upper RAM address bits are ignored, so addresses alias.
- Write (en=1, wen!=0):
  - Each lane i with wen[i]=1 replaces byte i of the target word at that edge; other lanes are unchanged.
  - rdata is unchanged by writes.
- Read (en=1, wen=0):
  - rdata updates at the sampling edge, so it is valid the cycle after the request.
  - rdata holds until the next accepted read.
- Read-after-write:
  - Write in cycle N and read of the same word in cycle N+1 returns the merged new value.
  - A single port means there are no same-cycle read/write collisions.
- MMIO offsets (addr[15:0]):
  - 16'hF000 LED (R/W, 32-bit storage; led = bits [15:0]).
  - 16'hF004 scratch (R/W).
  - 16'hE000 timer (R/W).
  - Other offsets read 0; writes to them are ignored.
- Timer:
  - Increments by 1 every clock edge when not being written. Wraps 32'hFFFFFFFF to 0.
  - timer_irq=1 for exactly the one cycle following the wrap edge.
  - A write loads the byte-merged value (current timer value, selected lanes replaced) at that edge with no increment that edge; incrementing resumes on the next edge.
  - A read returns the timer value as held just before the sampling edge.
  - Writing a value of 32'hFFFFFFFF produces a wrap, and therefore an irq, on the following edge.
- Latency: fixed 1 cycle for reads; 0 extra cycles for writes (committed at the sampling edge).

Test Plan:
- Reset then idle:
  - Assert rst mid-cycle (asynchronously) -> rdata=0, led=0, timer_irq=0 immediately, with no clock edge required.
  - Release rst and hold en=0 for 5 cycles -> a subsequent read of 0xBFAFE000 returns 5 + (edges between release and the sample).
- Full-word write/read:
  - Write 0xDEADBEEF to 0x00000010 (wen=4'hF), then read 0x00000010 in the next cycle -> rdata=0xDEADBEEF one cycle after the read.
  - Aliased read at 0x00001010 (ADDR_WIDTH=10) -> 0xDEADBEEF.
- Byte merge:
  - After the previous write, write 0x11223344 with wen=4'b0101 to 0x10 -> read returns 0xDE22BE44.
  - wen=4'b1000 with wdata 0xAA000000 -> 0xAA22BE44.
- LED and unmapped MMIO:
  - Write 0x0001A5A5 to 0xBFAFF000 -> led=16'hA5A5 the cycle after; reading it returns 0x0001A5A5.
  - Write to 0xBFAF1234, then read it -> rdata=0, and led is unchanged.
- Timer load/wrap:
  - Write 0xFFFFFFFE to 0xBFAFE000 (wen=4'hF) -> the next edge gives 0xFFFFFFFF, the following edge gives 0.
  - timer_irq is high for exactly one cycle after the wrap.
  - A read issued 3 edges after the load returns 0x00000000.
- Read hold and write-doesn't-disturb:
  - Read 0x10 (value V), then write 0x5 to 0x20, then idle 3 cycles -> rdata stays V throughout.
  - A following read of 0x20 -> 0x00000005.
